// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master byte sequencer: drives sclk/cs_n/mosi, strobes the external
// SIPO once per bit and captures its parallel output at byte end.
module spi_master_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       last,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    output logic       shift_en,
    input  logic [7:0] sipo_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        WAIT  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  bit_r, bit_s;
    logic [7:0]  tx_r, tx_s;
    logic        last_r, last_s;
    logic        sclk_r, sclk_s;
    logic        cs_n_r, cs_n_s;
    logic        mosi_r, mosi_s;
    logic        shift_en_r, shift_en_s;
    logic        done_r, done_s;
    logic [7:0]  rx_r, rx_s;

    // Next-state and next-output decode; every register gets a default first
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + 16'd1;
        bit_s      = bit_r;
        tx_s       = tx_r;
        last_s     = last_r;
        sclk_s     = sclk_r;
        cs_n_s     = cs_n_r;
        mosi_s     = mosi_r;
        shift_en_s = 1'b0;
        done_s     = 1'b0;
        rx_s       = rx_r;
        case (state_r)
            IDLE: begin
                cnt_s = 16'd0;
                if (start) begin
                    tx_s    = tx_data;
                    last_s  = last;
                    cs_n_s  = 1'b0;
                    mosi_s  = tx_data[7];
                    bit_s   = 3'd0;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == 16'(CS_SETUP - 1)) begin
                    cnt_s   = 16'd0;
                    state_s = LOW;
                end else begin
                    state_s = SETUP;
                end
            end
            LOW: begin
                if (cnt_r == 16'(CLK_DIV - 1)) begin
                    cnt_s      = 16'd0;
                    sclk_s     = 1'b1;
                    shift_en_s = 1'b1;
                    state_s    = HIGH;
                end else begin
                    state_s = LOW;
                end
            end
            HIGH: begin
                if (cnt_r == 16'(CLK_DIV - 1)) begin
                    cnt_s  = 16'd0;
                    sclk_s = 1'b0;
                    if (bit_r != 3'd7) begin
                        bit_s   = bit_r + 3'd1;
                        tx_s    = {tx_r[6:0], 1'b0};
                        mosi_s  = tx_r[6];
                        state_s = LOW;
                    end else begin
                        rx_s    = sipo_data;
                        done_s  = 1'b1;
                        state_s = last_r ? HOLD : WAIT;
                    end
                end else begin
                    state_s = HIGH;
                end
            end
            WAIT: begin
                // Burst continuation skips SETUP since cs_n never went high
                cnt_s = 16'd0;
                if (start) begin
                    tx_s    = tx_data;
                    last_s  = last;
                    mosi_s  = tx_data[7];
                    bit_s   = 3'd0;
                    state_s = LOW;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (cnt_r == 16'(CS_HOLD - 1)) begin
                    cnt_s   = 16'd0;
                    cs_n_s  = 1'b1;
                    mosi_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                cnt_s   = 16'd0;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b0;
                mosi_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 16'd0;
            bit_r      <= 3'd0;
            tx_r       <= 8'h00;
            last_r     <= 1'b0;
            sclk_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            shift_en_r <= 1'b0;
            done_r     <= 1'b0;
            rx_r       <= 8'h00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_r      <= bit_s;
            tx_r       <= tx_s;
            last_r     <= last_s;
            sclk_r     <= sclk_s;
            cs_n_r     <= cs_n_s;
            mosi_r     <= mosi_s;
            shift_en_r <= shift_en_s;
            done_r     <= done_s;
            rx_r       <= rx_s;
        end
    end

    assign ready    = (state_r == IDLE) || (state_r == WAIT);
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign rx_byte  = rx_r;
    assign sclk     = sclk_r;
    assign cs_n     = cs_n_r;
    assign mosi     = mosi_r;
    assign shift_en = shift_en_r;

endmodule
